// File: rtl/fineps_sweep_controller.sv
// Fine-phase-shift sequencer: walks the tracked MMCM phase position one incr/decr step
// at a time towards an absolute or relative target, with lock gating, abort and step timeout.
module fineps_sweep_controller #(
    parameter int INT_POS_WIDTH      = 16,
    parameter int INT_TIMEOUT_CYCLES = 1023,
    parameter int INT_SETTLE_CYCLES  = 16
) (
    input  logic                            in_clk,
    input  logic                            in_rst_n,
    input  logic                            in_cmd_valid,
    output logic                            out_cmd_ready,
    input  logic                            in_cmd_relative,
    input  logic signed [INT_POS_WIDTH-1:0] in_cmd_value,
    input  logic                            in_abort,
    input  logic                            in_locked,
    input  logic                            in_fineps_dready,
    output logic                            out_fineps_valid,
    output logic                            out_fineps_incr,
    output logic                            out_fineps_decr,
    output logic signed [INT_POS_WIDTH-1:0] out_position,
    output logic                            out_busy,
    output logic                            out_done,
    output logic                            out_error
);

    localparam int W       = INT_POS_WIDTH;
    localparam int CNT_MAX = (INT_TIMEOUT_CYCLES > INT_SETTLE_CYCLES) ? INT_TIMEOUT_CYCLES : INT_SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0]    CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]    TMO_LAST    = CNT_W'(INT_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'((INT_SETTLE_CYCLES > 0) ? (INT_SETTLE_CYCLES - 1) : 0);
    localparam logic signed [W-1:0] POS_ONE     = W'(1'b1);
    localparam logic signed [W-1:0] POS_MAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] POS_MIN     = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_ERROR     = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic signed [W-1:0]   pos_q, pos_d;
    logic signed [W-1:0]   tgt_q, tgt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  abort_q, abort_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic                  incr_q, incr_d;
    logic                  decr_q, decr_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  busy_s;
    logic                  step_up_s;
    logic                  next_up_s;

    // Relative targets are summed one bit wider and clamped so a large delta never wraps.
    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b);
        logic [W:0] sum;
        sum = {a[W-1], a} + {b[W-1], b};
        if (sum[W] != sum[W-1]) begin
            sat_add = sum[W] ? POS_MIN : POS_MAX;
        end else begin
            sat_add = sum[W-1:0];
        end
    endfunction

    // Next-state and next-output computation for the sweep sequencer.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        busy_s    = (state_q != ST_IDLE) && (state_q != ST_ERROR);
        step_up_s = (tgt_q > pos_q);
        if (busy_s && in_abort) begin
            abort_d = 1'b1;
        end else begin
            abort_d = abort_q;
        end

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (in_cmd_valid) begin
                    tgt_d   = in_cmd_relative ? sat_add(pos_q, in_cmd_value) : in_cmd_value;
                    err_d   = 1'b0;
                    abort_d = 1'b0;
                    state_d = ST_CHECK;
                end else begin
                    state_d = state_q;
                end
            end
            ST_CHECK: begin
                // done_q already holds "position == target or abort latched" for this cycle.
                if (done_q) begin
                    abort_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (in_locked && in_fineps_dready) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // cnt_q == 0 is the blanking cycle while the synthesizer drops dready.
                if ((cnt_q != CNT_ZERO) && in_fineps_dready) begin
                    pos_d   = step_up_s ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
                    cnt_d   = CNT_ZERO;
                    state_d = (INT_SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
                end else if (cnt_q >= TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q >= SETTLE_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        next_up_s = (tgt_d > pos_d);
        done_d    = (state_d == ST_CHECK) && ((pos_d == tgt_d) || abort_d);
        valid_d   = (state_d == ST_ISSUE);
        incr_d    = valid_d && next_up_s;
        decr_d    = valid_d && !next_up_s;
        ready_d   = (state_d == ST_IDLE) || (state_d == ST_ERROR);
        busy_d    = !ready_d;
    end

    // State, position and registered outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= ST_IDLE;
            pos_q   <= {W{1'b0}};
            tgt_q   <= {W{1'b0}};
            cnt_q   <= CNT_ZERO;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            incr_q  <= 1'b0;
            decr_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            incr_q  <= incr_d;
            decr_q  <= decr_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign out_cmd_ready    = ready_q;
    assign out_busy         = busy_q;
    assign out_fineps_valid = valid_q;
    assign out_fineps_incr  = incr_q;
    assign out_fineps_decr  = decr_q;
    assign out_position     = pos_q;
    assign out_done         = done_q;
    assign out_error        = err_q;

endmodule

// File: tb/tb_fineps_sweep_controller.sv
// Scoreboard bench for fineps_sweep_controller: a synthesizer model answers steps, a monitor
// checks every step/done/error event against expectations queued by the stimulus.
module tb_fineps_sweep_controller;

    localparam int W  = 16;
    localparam int SW = 4;

    typedef struct packed {
        logic                up;
        logic signed [W-1:0] pos;
    } step_t;

    logic                 clk;
    logic                 rst_n;
    logic                 cmd_valid, cmd_relative, abort, locked, dready;
    logic signed [W-1:0]  cmd_value;
    logic                 cmd_ready, fps_valid, fps_incr, fps_decr, busy, done, error;
    logic signed [W-1:0]  position;

    logic                 s_cmd_valid, s_cmd_relative, s_abort, s_locked, s_dready;
    logic signed [SW-1:0] s_cmd_value;
    logic                 s_cmd_ready, s_valid, s_incr, s_decr, s_busy, s_done, s_error;
    logic signed [SW-1:0] s_position;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    valid_cnt = 0;
    int    done_cnt = 0;
    int    err_cnt = 0;
    int    last_valid_cyc = 0;
    logic  have_last = 1'b0;
    logic  prev_valid = 1'b0;
    logic  prev_err = 1'b0;
    logic  hang = 1'b0;

    step_t               step_q[$];
    logic signed [W-1:0] done_q[$];
    logic signed [W-1:0] err_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fineps_sweep_controller #(.INT_POS_WIDTH(W), .INT_TIMEOUT_CYCLES(20), .INT_SETTLE_CYCLES(4)) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_cmd_valid(cmd_valid), .out_cmd_ready(cmd_ready),
        .in_cmd_relative(cmd_relative), .in_cmd_value(cmd_value), .in_abort(abort),
        .in_locked(locked), .in_fineps_dready(dready), .out_fineps_valid(fps_valid),
        .out_fineps_incr(fps_incr), .out_fineps_decr(fps_decr), .out_position(position),
        .out_busy(busy), .out_done(done), .out_error(error));

    fineps_sweep_controller #(.INT_POS_WIDTH(SW), .INT_TIMEOUT_CYCLES(8), .INT_SETTLE_CYCLES(0)) dut_s (
        .in_clk(clk), .in_rst_n(rst_n), .in_cmd_valid(s_cmd_valid), .out_cmd_ready(s_cmd_ready),
        .in_cmd_relative(s_cmd_relative), .in_cmd_value(s_cmd_value), .in_abort(s_abort),
        .in_locked(s_locked), .in_fineps_dready(s_dready), .out_fineps_valid(s_valid),
        .out_fineps_incr(s_incr), .out_fineps_decr(s_decr), .out_position(s_position),
        .out_busy(s_busy), .out_done(s_done), .out_error(s_error));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event with no expectation queued at cycle %0d", name, cyc);
    endtask

    task automatic push_steps(input logic up, input int from, input int n);
        step_t s;
        int p;
        for (int i = 0; i < n; i++) begin
            p     = up ? from + i : from - i;
            s.up  = up;
            s.pos = p[W-1:0];
            step_q.push_back(s);
        end
    endtask

    task automatic push_done(input int p);
        logic signed [W-1:0] v;
        v = p[W-1:0];
        done_q.push_back(v);
    endtask

    task automatic push_err(input int p);
        logic signed [W-1:0] v;
        v = p[W-1:0];
        err_q.push_back(v);
    endtask

    // Called just after a negedge; returns at the negedge of cycle N+1.
    task automatic send(input logic rel, input int val);
        cmd_valid    = 1'b1;
        cmd_relative = rel;
        cmd_value    = val[W-1:0];
        @(negedge clk);
        cmd_valid    = 1'b0;
    endtask

    task automatic s_send(input logic rel, input int val);
        s_cmd_valid    = 1'b1;
        s_cmd_relative = rel;
        s_cmd_value    = val[SW-1:0];
        @(negedge clk);
        s_cmd_valid    = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        int base;
        int n;
        base = done_cnt + err_cnt;
        n    = 0;
        while ((done_cnt + err_cnt == base) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt + err_cnt == base) begin
            unexpected({name, "_no_completion_within_budget"});
        end
        @(negedge clk);
        chk({name, "_steps_left"}, step_q.size(), 0);
        chk({name, "_done_left"}, done_q.size(), 0);
    endtask

    task automatic wait_valids(input int target, input int budget);
        int n;
        n = 0;
        while ((valid_cnt < target) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk("wait_step_pulses", int'(valid_cnt >= target), 1);
    endtask

    task automatic s_wait_done(input string name, input int budget, output int incs, output int decs);
        int n;
        incs = 0;
        decs = 0;
        n    = 0;
        while ((s_done !== 1'b1) && (n < budget)) begin
            if (s_valid) begin
                if (s_incr) incs++;
                if (s_decr) decs++;
            end
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, int'(s_done), 1);
    endtask

    // Synthesizer model: dready drops after a step request and returns 12 cycles later.
    initial begin
        dready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && fps_valid) begin
                dready = 1'b0;
                repeat (12) @(negedge clk);
                while (hang) @(negedge clk);
                dready = 1'b1;
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents a step, done or error event.
    initial begin
        step_t e;
        logic signed [W-1:0] p;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                have_last  = 1'b0;
                prev_valid = 1'b0;
                prev_err   = 1'b0;
            end else begin
                if (fps_valid) begin
                    valid_cnt++;
                    chk("valid_back_to_back", int'(prev_valid), 0);
                    if (have_last) chk("step_gap_ge_18", int'((cyc - last_valid_cyc) >= 18), 1);
                    last_valid_cyc = cyc;
                    have_last      = 1'b1;
                    if (step_q.size() == 0) begin
                        unexpected("step");
                    end else begin
                        e = step_q.pop_front();
                        chk("step_incr", int'(fps_incr), int'(e.up));
                        chk("step_decr", int'(fps_decr), int'(!e.up));
                        chk("step_position", int'(position), int'(e.pos));
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (done_q.size() == 0) begin
                        unexpected("done");
                    end else begin
                        p = done_q.pop_front();
                        chk("done_position", int'(position), int'(p));
                    end
                end
                if (error && !prev_err) begin
                    err_cnt++;
                    if (err_q.size() == 0) begin
                        unexpected("error");
                    end else begin
                        p = err_q.pop_front();
                        chk("error_position", int'(position), int'(p));
                        chk("timeout_latency", cyc - last_valid_cyc, 21);
                    end
                end
                prev_valid = fps_valid;
                prev_err   = error;
            end
        end
    end

    initial begin
        int incs;
        int decs;
        int nv;
        int base;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_relative = 1'b0; cmd_value = '0;
        abort = 1'b0; locked = 1'b1;
        s_cmd_valid = 1'b0; s_cmd_relative = 1'b0; s_cmd_value = '0;
        s_abort = 1'b0; s_locked = 1'b1; s_dready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", int'(cmd_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(fps_valid), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_error", int'(error), 0);
        chk("reset_position", int'(position), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Relative +3 from 0
        push_steps(1'b1, 0, 3);
        push_done(3);
        send(1'b1, 3);
        chk("accept_busy_n1", int'(busy), 1);
        chk("accept_ready_n1", int'(cmd_ready), 0);
        wait_end("rel_plus3", 400);
        chk("rel_plus3_position", int'(position), 3);

        // Absolute -2 from 3
        push_steps(1'b0, 3, 5);
        push_done(-2);
        send(1'b0, -2);
        wait_end("abs_minus2", 600);
        chk("abs_minus2_position", int'(position), -2);

        // Zero-distance command
        push_done(-2);
        send(1'b0, -2);
        chk("zero_done_n1", int'(done), 1);
        chk("zero_ready_n1", int'(cmd_ready), 0);
        @(negedge clk);
        chk("zero_ready_n2", int'(cmd_ready), 1);
        chk("zero_done_n2", int'(done), 0);
        chk("zero_busy_n2", int'(busy), 0);

        // Step timeout
        hang = 1'b1;
        push_steps(1'b1, -2, 1);
        push_err(-2);
        send(1'b1, 1);
        wait_end("timeout", 200);
        chk("timeout_error", int'(error), 1);
        chk("timeout_ready", int'(cmd_ready), 1);
        chk("timeout_busy", int'(busy), 0);
        chk("timeout_position", int'(position), -2);
        hang = 1'b0;
        repeat (3) @(negedge clk);
        push_done(-2);
        send(1'b0, -2);
        chk("error_cleared_by_cmd", int'(error), 0);
        chk("after_error_done", int'(done), 1);
        @(negedge clk);

        // Lock gating then abort during the second step of +10
        locked = 1'b0;
        push_steps(1'b1, -2, 2);
        push_done(0);
        base = valid_cnt;
        send(1'b1, 10);
        nv = 0;
        repeat (30) begin
            @(negedge clk);
            if (fps_valid) nv++;
        end
        chk("unlocked_no_step", nv, 0);
        chk("unlocked_busy", int'(busy), 1);
        locked = 1'b1;
        wait_valids(base + 2, 200);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_end("abort", 200);
        chk("abort_position", int'(position), 0);
        chk("abort_ready", int'(cmd_ready), 1);

        // Saturation on a 4-bit instance
        s_send(1'b0, 7);
        s_wait_done("s_abs7", 100, incs, decs);
        chk("s_abs7_incr_steps", incs, 7);
        chk("s_abs7_decr_steps", decs, 0);
        chk("s_abs7_position", int'(s_position), 7);
        @(negedge clk);
        s_send(1'b1, 5);
        chk("s_sat_hi_done_n1", int'(s_done), 1);
        chk("s_sat_hi_busy_n1", int'(s_busy), 1);
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (s_valid) nv++;
        end
        chk("s_sat_hi_no_step", nv, 0);
        chk("s_sat_hi_position", int'(s_position), 7);
        chk("s_sat_hi_ready", int'(s_cmd_ready), 1);
        s_send(1'b0, -8);
        s_wait_done("s_absm8", 200, incs, decs);
        chk("s_absm8_decr_steps", decs, 15);
        chk("s_absm8_position", int'(s_position), -8);
        @(negedge clk);
        s_send(1'b1, -5);
        chk("s_sat_lo_done_n1", int'(s_done), 1);
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (s_valid) nv++;
        end
        chk("s_sat_lo_no_step", nv, 0);
        chk("s_sat_lo_position", int'(s_position), -8);
        chk("s_error_never", int'(s_error), 0);

        // Asynchronous reset in the middle of a step
        push_steps(1'b1, 0, 2);
        base = valid_cnt;
        send(1'b1, 4);
        wait_valids(base + 2, 200);
        repeat (3) @(negedge clk);
        chk("pos_before_reset", int'(position), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_ready", int'(cmd_ready), 1);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_valid", int'(fps_valid), 0);
        chk("midreset_incr", int'(fps_incr), 0);
        chk("midreset_decr", int'(fps_decr), 0);
        chk("midreset_done", int'(done), 0);
        chk("midreset_error", int'(error), 0);
        chk("midreset_position", int'(position), 0);
        step_q.delete();
        done_q.delete();
        err_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_done(0);
        send(1'b0, 0);
        chk("post_reset_zero_done", int'(done), 1);
        @(negedge clk);
        chk("post_reset_done_left", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
